// File: rtl/reorder_buffer_pkg.sv
// Shared ROB sizing, entry type encodings and id/slot conversion helpers.
package reorder_buffer_pkg;
    localparam int ROB_SIZE = 16;
    localparam int ROBBW    = 5;
    localparam int REGBW    = 5;
    localparam int PTRW     = $clog2(ROB_SIZE);
    localparam int CNTW     = PTRW + 1;

    typedef enum logic [1:0] {
        ROB_REG   = 2'd0,
        ROB_STORE = 2'd1,
        ROB_BR    = 2'd2
    } rob_type_e;

    localparam logic [ROBBW-1:0] NO_ROB = '0;
    localparam logic [ROBBW-1:0] MAX_ID = ROBBW'(ROB_SIZE);

    // Ids are slot index + 1 so that NO_ROB can mean "no producer".
    function automatic logic [ROBBW-1:0] slot_to_id(input logic [PTRW-1:0] slot);
        return ROBBW'(slot) + ROBBW'(1);
    endfunction

    function automatic logic [PTRW-1:0] id_to_slot(input logic [ROBBW-1:0] id);
        return PTRW'(id - ROBBW'(1));
    endfunction

    function automatic logic id_valid(input logic [ROBBW-1:0] id);
        return (id != NO_ROB) && (id <= MAX_ID);
    endfunction
endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: allocates ids at issue, captures CDB results,
// serves operand lookups, retires the head in program order and flushes on mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,

    input  logic              issue_flag,
    input  logic [1:0]        issue_type,
    input  logic [REGBW-1:0]  issue_rd,
    input  logic [31:0]       issue_pc,
    input  logic              issue_pred,
    output logic [ROBBW-1:0]  alloc_id,
    output logic              rob_full,

    input  logic [ROBBW-1:0]  id1,
    input  logic [ROBBW-1:0]  id2,
    output logic              id1_ready,
    output logic              id2_ready,
    output logic [31:0]       id1_val,
    output logic [31:0]       id2_val,

    input  logic              ex_cdb_flag,
    input  logic [ROBBW-1:0]  ex_cdb_rob_id,
    input  logic [31:0]       ex_cdb_val,
    input  logic              ex_cdb_jump,
    input  logic [31:0]       ex_cdb_target,

    input  logic              ld_cdb_flag,
    input  logic [ROBBW-1:0]  ld_cdb_rob_id,
    input  logic [31:0]       ld_cdb_val,

    output logic              flag_ROB,
    output logic [REGBW-1:0]  rd_ROB,
    output logic [ROBBW-1:0]  id_ROB,
    output logic [31:0]       val_ROB,
    output logic              st_commit_flag,
    output logic [ROBBW-1:0]  st_commit_id,
    output logic              jump_wrong,
    output logic [31:0]       correct_pc
);

    // Handshake: issue_flag and the CDB flags are single-cycle strobes with no
    // back-pressure; the issuer must watch rob_full, and every commit output is a
    // one-cycle pulse qualified by its flag (jump_wrong qualifies correct_pc).

    logic [ROB_SIZE-1:0] busy_q;
    logic [ROB_SIZE-1:0] ready_q;
    logic [ROB_SIZE-1:0] pred_q;
    logic [ROB_SIZE-1:0] jump_q;
    rob_type_e           type_q   [ROB_SIZE];
    logic [REGBW-1:0]    rd_q     [ROB_SIZE];
    logic [31:0]         pc_q     [ROB_SIZE];
    logic [31:0]         target_q [ROB_SIZE];
    logic [31:0]         val_q    [ROB_SIZE];

    logic [PTRW-1:0]     head_q;
    logic [PTRW-1:0]     tail_q;
    logic [CNTW-1:0]     count_q;

    logic [PTRW-1:0]     slot1;
    logic [PTRW-1:0]     slot2;
    logic [PTRW-1:0]     ex_slot;
    logic [PTRW-1:0]     ld_slot;
    logic                ex_hit;
    logic                ld_hit;
    logic                commit;

    assign alloc_id = slot_to_id(tail_q);
    assign rob_full = count_q >= CNTW'(ROB_SIZE - 1);

    assign slot1     = id_to_slot(id1);
    assign slot2     = id_to_slot(id2);
    assign id1_ready = id_valid(id1) && busy_q[slot1] && ready_q[slot1];
    assign id2_ready = id_valid(id2) && busy_q[slot2] && ready_q[slot2];
    assign id1_val   = id1_ready ? val_q[slot1] : 32'd0;
    assign id2_val   = id2_ready ? val_q[slot2] : 32'd0;

    assign ex_slot = id_to_slot(ex_cdb_rob_id);
    assign ld_slot = id_to_slot(ld_cdb_rob_id);
    assign ex_hit  = ex_cdb_flag && id_valid(ex_cdb_rob_id) && busy_q[ex_slot];
    assign ld_hit  = ld_cdb_flag && id_valid(ld_cdb_rob_id) && busy_q[ld_slot];

    // The cycle carrying jump_wrong is reserved for the flush, so nothing retires in it.
    assign commit = (count_q != '0) && busy_q[head_q] && ready_q[head_q] && !jump_wrong;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            pred_q         <= '0;
            jump_q         <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                type_q[i]   <= ROB_REG;
                rd_q[i]     <= '0;
                pc_q[i]     <= '0;
                target_q[i] <= '0;
                val_q[i]    <= '0;
            end
            flag_ROB       <= 1'b0;
            rd_ROB         <= '0;
            id_ROB         <= NO_ROB;
            val_ROB        <= '0;
            st_commit_flag <= 1'b0;
            st_commit_id   <= NO_ROB;
            jump_wrong     <= 1'b0;
            correct_pc     <= '0;
        end else if (rdy) begin
            flag_ROB       <= 1'b0;
            rd_ROB         <= '0;
            id_ROB         <= NO_ROB;
            val_ROB        <= '0;
            st_commit_flag <= 1'b0;
            st_commit_id   <= NO_ROB;
            jump_wrong     <= 1'b0;
            correct_pc     <= '0;

            if (jump_wrong) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                busy_q  <= '0;
            end else begin
                if (ex_hit) begin
                    ready_q[ex_slot]  <= 1'b1;
                    val_q[ex_slot]    <= ex_cdb_val;
                    jump_q[ex_slot]   <= ex_cdb_jump;
                    target_q[ex_slot] <= ex_cdb_target;
                end
                if (ld_hit) begin
                    ready_q[ld_slot] <= 1'b1;
                    val_q[ld_slot]   <= ld_cdb_val;
                end

                if (commit) begin
                    busy_q[head_q] <= 1'b0;
                    head_q         <= head_q + PTRW'(1);
                    case (type_q[head_q])
                        ROB_REG: begin
                            flag_ROB <= 1'b1;
                            rd_ROB   <= rd_q[head_q];
                            id_ROB   <= slot_to_id(head_q);
                            val_ROB  <= val_q[head_q];
                        end
                        ROB_STORE: begin
                            st_commit_flag <= 1'b1;
                            st_commit_id   <= slot_to_id(head_q);
                        end
                        ROB_BR: begin
                            if (jump_q[head_q] != pred_q[head_q]) begin
                                jump_wrong <= 1'b1;
                                correct_pc <= jump_q[head_q] ? target_q[head_q]
                                                             : pc_q[head_q] + 32'd4;
                            end
                        end
                        default: ;
                    endcase
                end

                // Issue is written last so a fresh allocation owns its slot outright.
                if (issue_flag) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    type_q[tail_q]  <= rob_type_e'(issue_type);
                    rd_q[tail_q]    <= issue_rd;
                    pc_q[tail_q]    <= issue_pc;
                    pred_q[tail_q]  <= issue_pred;
                    tail_q          <= tail_q + PTRW'(1);
                end

                if (issue_flag && !commit) begin
                    count_q <= count_q + CNTW'(1);
                end else if (!issue_flag && commit) begin
                    count_q <= count_q - CNTW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: commit events are predicted into exp_q at
// stimulus time and a negedge monitor pops and compares each observed pulse.
module tb_reorder_buffer;

    localparam int EW = 44;
    localparam logic [1:0] T_REG = 2'd0;
    localparam logic [1:0] T_ST  = 2'd1;
    localparam logic [1:0] T_BR  = 2'd2;
    localparam logic [1:0] K_REG = 2'd1;
    localparam logic [1:0] K_ST  = 2'd2;
    localparam logic [1:0] K_JW  = 2'd3;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        issue_flag, issue_pred;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic [4:0]  alloc_id;
    logic        rob_full;
    logic [4:0]  id1, id2;
    logic        id1_ready, id2_ready;
    logic [31:0] id1_val, id2_val;
    logic        ex_cdb_flag, ex_cdb_jump;
    logic [4:0]  ex_cdb_rob_id;
    logic [31:0] ex_cdb_val, ex_cdb_target;
    logic        ld_cdb_flag;
    logic [4:0]  ld_cdb_rob_id;
    logic [31:0] ld_cdb_val;
    logic        flag_ROB, st_commit_flag, jump_wrong;
    logic [4:0]  rd_ROB, id_ROB, st_commit_id;
    logic [31:0] val_ROB, correct_pc;

    logic [EW-1:0] exp_q[$];
    logic [4:0]    sid_q[$];
    logic [31:0]   sval_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [4:0]    exp_id;
    logic          allow_full;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_flag(issue_flag), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_pred(issue_pred),
        .alloc_id(alloc_id), .rob_full(rob_full),
        .id1(id1), .id2(id2), .id1_ready(id1_ready), .id2_ready(id2_ready),
        .id1_val(id1_val), .id2_val(id2_val),
        .ex_cdb_flag(ex_cdb_flag), .ex_cdb_rob_id(ex_cdb_rob_id), .ex_cdb_val(ex_cdb_val),
        .ex_cdb_jump(ex_cdb_jump), .ex_cdb_target(ex_cdb_target),
        .ld_cdb_flag(ld_cdb_flag), .ld_cdb_rob_id(ld_cdb_rob_id), .ld_cdb_val(ld_cdb_val),
        .flag_ROB(flag_ROB), .rd_ROB(rd_ROB), .id_ROB(id_ROB), .val_ROB(val_ROB),
        .st_commit_flag(st_commit_flag), .st_commit_id(st_commit_id),
        .jump_wrong(jump_wrong), .correct_pc(correct_pc)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [EW-1:0] mk_ev(input logic [1:0] k, input logic [4:0] rd,
                                            input logic [4:0] id, input logic [31:0] v);
        return {k, rd, id, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_event(input string name, input logic [EW-1:0] act);
        logic [EW-1:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: unexpected event 0x%0h, nothing expected", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, e);
            end
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (flag_ROB)       compare_event("reg_commit", mk_ev(K_REG, rd_ROB, id_ROB, val_ROB));
            if (st_commit_flag) compare_event("store_commit", mk_ev(K_ST, 5'd0, st_commit_id, 32'd0));
            if (jump_wrong)     compare_event("flush", mk_ev(K_JW, 5'd0, 5'd0, correct_pc));
        end
    end

    // Driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
        issue_flag  = 1'b0;
        ex_cdb_flag = 1'b0;
        ld_cdb_flag = 1'b0;
    endtask

    task automatic set_ex(input logic [4:0] id, input logic [31:0] v,
                          input logic jmp, input logic [31:0] tgt);
        ex_cdb_flag   = 1'b1;
        ex_cdb_rob_id = id;
        ex_cdb_val    = v;
        ex_cdb_jump   = jmp;
        ex_cdb_target = tgt;
    endtask

    task automatic set_ld(input logic [4:0] id, input logic [31:0] v);
        ld_cdb_flag   = 1'b1;
        ld_cdb_rob_id = id;
        ld_cdb_val    = v;
    endtask

    task automatic do_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                            input logic pred, input logic [31:0] v, input bit want,
                            output logic [4:0] id);
        check("alloc_id", 32'(alloc_id), 32'(exp_id));
        check("issue_not_full", 32'(rob_full & ~allow_full), 32'd0);
        id         = exp_id;
        issue_flag = 1'b1;
        issue_type = t;
        issue_rd   = rd;
        issue_pc   = pc;
        issue_pred = pred;
        if (want && t == T_REG) exp_q.push_back(mk_ev(K_REG, rd, exp_id, v));
        if (want && t == T_ST)  exp_q.push_back(mk_ev(K_ST, 5'd0, exp_id, 32'd0));
        exp_id = (exp_id == 5'd16) ? 5'd1 : exp_id + 5'd1;
    endtask

    initial begin
        logic [4:0]  id, bid;
        logic [31:0] v;
        int          n_new;

        rst = 1'b1; rdy = 1'b1; allow_full = 1'b0; exp_id = 5'd1;
        issue_flag = 0; issue_type = T_REG; issue_rd = 0; issue_pc = 0; issue_pred = 0;
        id1 = 0; id2 = 0;
        ex_cdb_flag = 0; ex_cdb_rob_id = 0; ex_cdb_val = 0; ex_cdb_jump = 0; ex_cdb_target = 0;
        ld_cdb_flag = 0; ld_cdb_rob_id = 0; ld_cdb_val = 0;
        cycle();
        cycle();
        rst = 1'b0;

        check("rst_alloc_id", 32'(alloc_id), 32'd1);
        check("rst_rob_full", 32'(rob_full), 32'd0);
        check("rst_flag_ROB", 32'(flag_ROB), 32'd0);
        check("rst_val_ROB", val_ROB, 32'd0);
        check("rst_st_commit", 32'(st_commit_flag), 32'd0);
        check("rst_jump_wrong", 32'(jump_wrong), 32'd0);
        check("rst_correct_pc", correct_pc, 32'd0);
        check("rst_id2_ready", 32'(id2_ready), 32'd0);

        // Single REG: lookup sees the value before the registered commit
        do_issue(T_REG, 5'd5, 32'h100, 1'b0, 32'hAB, 1'b1, id);
        cycle();
        set_ex(id, 32'hAB, 1'b0, 32'd0);
        cycle();
        id1 = 5'd1; id2 = 5'd1;
        #1;
        check("lookup1_ready", 32'(id1_ready), 32'd1);
        check("lookup1_val", id1_val, 32'hAB);
        check("lookup2_val", id2_val, 32'hAB);
        cycle();
        check("retired_not_ready", 32'(id1_ready), 32'd0);
        id1 = 0; id2 = 0;

        // Out-of-order completion, in-order retirement on consecutive cycles
        do_issue(T_REG, 5'd1, 32'h104, 1'b0, 32'h11, 1'b1, id); cycle();
        do_issue(T_REG, 5'd2, 32'h108, 1'b0, 32'h22, 1'b1, id); cycle();
        do_issue(T_REG, 5'd3, 32'h10C, 1'b0, 32'h33, 1'b1, id); cycle();
        set_ex(5'd4, 32'h33, 1'b0, 32'd0); cycle();
        set_ex(5'd3, 32'h22, 1'b0, 32'd0); cycle();
        set_ex(5'd2, 32'h11, 1'b0, 32'd0); cycle();
        cycle();
        check("inorder_a", 32'(id_ROB), 32'd2);
        cycle();
        check("inorder_b", 32'(id_ROB), 32'd3);
        cycle();
        check("inorder_c", 32'(id_ROB), 32'd4);
        cycle();

        // Mispredicted taken branch flushes a completed younger entry
        do_issue(T_BR, 5'd0, 32'h200, 1'b0, 32'd0, 1'b0, bid); cycle();
        do_issue(T_REG, 5'd7, 32'h204, 1'b0, 32'h66, 1'b0, id); cycle();
        set_ex(bid, 32'd0, 1'b1, 32'h300);
        set_ld(id, 32'h66);
        exp_q.push_back(mk_ev(K_JW, 5'd0, 5'd0, 32'h300));
        cycle();
        cycle();
        check("jw_pulse", 32'(jump_wrong), 32'd1);
        check("jw_pc_taken", correct_pc, 32'h300);
        issue_flag = 1'b1; issue_type = T_REG; issue_rd = 5'd9;
        cycle();
        check("jw_dropped", 32'(jump_wrong), 32'd0);
        check("flush_alloc", 32'(alloc_id), 32'd1);
        check("flush_not_full", 32'(rob_full), 32'd0);
        exp_id = 5'd1;
        cycle();

        // Correct prediction retires silently; not-taken mispredict redirects to pc+4
        do_issue(T_BR, 5'd0, 32'h400, 1'b1, 32'd0, 1'b0, bid); cycle();
        do_issue(T_REG, 5'd4, 32'h404, 1'b0, 32'h44, 1'b1, id); cycle();
        set_ex(bid, 32'd0, 1'b1, 32'h500);
        set_ld(id, 32'h44);
        cycle();
        repeat (3) cycle();
        do_issue(T_BR, 5'd0, 32'h600, 1'b1, 32'd0, 1'b0, bid); cycle();
        set_ex(bid, 32'd0, 1'b0, 32'h999);
        exp_q.push_back(mk_ev(K_JW, 5'd0, 5'd0, 32'h604));
        cycle();
        cycle();
        check("jw_pc_fallthrough", correct_pc, 32'h604);
        cycle();
        exp_id = 5'd1;
        cycle();

        // Store retires through the store path only
        do_issue(T_ST, 5'd0, 32'h700, 1'b0, 32'd0, 1'b1, id); cycle();
        set_ld(id, 32'h1234); cycle();
        cycle();
        check("store_no_reg", 32'(flag_ROB), 32'd0);
        check("store_id", 32'(st_commit_id), 32'(id));
        cycle();

        // Fill to 15 entries, then same-cycle commit+issue, then stream 40 through
        for (int i = 0; i < 15; i++) begin
            if (i == 14) check("not_full_at_14", 32'(rob_full), 32'd0);
            v = 32'hC000_0000 + 32'(i);
            do_issue(T_REG, 5'(i + 1), 32'h1000 + 32'(4 * i), 1'b0, v, 1'b1, id);
            sid_q.push_back(id); sval_q.push_back(v);
            cycle();
        end
        check("full_at_15", 32'(rob_full), 32'd1);
        check("alloc_wraps", 32'(alloc_id), 32'd1);
        set_ex(sid_q.pop_front(), sval_q.pop_front(), 1'b0, 32'd0);
        cycle();
        allow_full = 1'b1;
        v = 32'hC000_0100;
        do_issue(T_REG, 5'd20, 32'h1100, 1'b0, v, 1'b1, id);
        sid_q.push_back(id); sval_q.push_back(v);
        cycle();
        allow_full = 1'b0;
        check("count_held_full", 32'(rob_full), 32'd1);
        check("alloc_after_wrap", 32'(alloc_id), 32'd2);

        n_new = 0;
        for (int g = 0; g < 400 && (n_new < 40 || sid_q.size() != 0); g++) begin
            if (sid_q.size() != 0) set_ex(sid_q.pop_front(), sval_q.pop_front(), 1'b0, 32'd0);
            if (n_new < 40 && !rob_full) begin
                v = 32'hD000_0000 + 32'(n_new);
                do_issue(T_REG, 5'(n_new % 31 + 1), 32'h2000 + 32'(4 * n_new), 1'b0, v, 1'b1, id);
                sid_q.push_back(id); sval_q.push_back(v);
                n_new++;
            end
            cycle();
        end
        check("stream_issued", 32'(n_new), 32'd40);
        repeat (4) cycle();

        // rdy low freezes a ready head entry and ignores issue
        do_issue(T_REG, 5'd10, 32'h800, 1'b0, 32'h77, 1'b1, id); cycle();
        set_ex(id, 32'h77, 1'b0, 32'd0); cycle();
        rdy = 1'b0; id1 = id;
        issue_flag = 1'b1; issue_type = T_REG; issue_rd = 5'd30;
        for (int i = 0; i < 5; i++) begin
            cycle();
            issue_flag = 1'b1;
            check("hold_no_commit", 32'(flag_ROB), 32'd0);
            check("hold_alloc", 32'(alloc_id), 32'(exp_id));
            check("hold_lookup", 32'(id1_ready), 32'd1);
        end
        issue_flag = 1'b0; rdy = 1'b1;
        cycle();
        check("resume_commit", 32'(flag_ROB), 32'd1);
        id1 = 0;

        // Reset mid-stream wins over a pending commit
        do_issue(T_REG, 5'd11, 32'h900, 1'b0, 32'hBB, 1'b0, id); cycle();
        set_ex(id, 32'hBB, 1'b0, 32'd0); cycle();
        id1 = id; rst = 1'b1;
        cycle();
        check("mid_rst_flag", 32'(flag_ROB), 32'd0);
        check("mid_rst_val", val_ROB, 32'd0);
        check("mid_rst_alloc", 32'(alloc_id), 32'd1);
        check("mid_rst_full", 32'(rob_full), 32'd0);
        check("mid_rst_lookup", 32'(id1_ready), 32'd0);
        rst = 1'b0; id1 = 0; exp_id = 5'd1;
        do_issue(T_REG, 5'd12, 32'hA00, 1'b0, 32'hCC, 1'b1, id); cycle();
        set_ex(id, 32'hCC, 1'b0, 32'd0); cycle();

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle();
        cycle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular in-order commit buffer for the Tomasulo core. It sits between issue/decode, the two CDBs (ALU and load/store), the register file and the load/store buffer. It allocates ROB ids at issue and captures results from the CDBs. It answers the register file's operand-readiness lookups, retires the head entry in program order, and raises `jump_wrong` on a branch mispredict to flush the machine.

Parameters:
- ROB_SIZE, 16, number of entries; power of two.
- ROBBW, 5, ROB id width; id = slot index + 1, and id 0 means "no entry".
- REGBW, 5, architectural register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state and outputs hold
- issue_flag  in  1  allocate an entry this cycle
- issue_type  in  2  0=REG, 1=STORE, 2=BRANCH
- issue_rd  in  REGBW  destination register (REG only)
- issue_pc  in  32  instruction PC
- issue_pred  in  1  predicted taken (BRANCH)
- alloc_id  out  ROBBW  id the next issue will receive (tail+1), combinational
- rob_full  out  1  combinational; count >= ROB_SIZE-1
- id1, id2  in  ROBBW  lookup ids from the register file
- id1_ready, id2_ready  out  1  entry valid and result captured
- id1_val, id2_val  out  32  captured result
- ex_cdb_flag, ex_cdb_rob_id, ex_cdb_val  in  1/ROBBW/32  ALU broadcast
- ex_cdb_jump  in  1  actual branch outcome (taken)
- ex_cdb_target  in  32  branch target when taken
- ld_cdb_flag, ld_cdb_rob_id, ld_cdb_val  in  1/ROBBW/32  load/store broadcast; for stores this means address and data are ready
- flag_ROB, rd_ROB, id_ROB, val_ROB  out  1/REGBW/ROBBW/32  register commit to the register file, registered
- st_commit_flag, st_commit_id  out  1/ROBBW  store may now write memory, registered
- jump_wrong  out  1  flush pulse, registered
- correct_pc  out  32  redirect PC, valid while jump_wrong=1

Behaviour:
- Storage per slot: busy, ready, type, rd, pc, pred, jump, target, val. Pointers head and tail are mod ROB_SIZE; count ranges 0..ROB_SIZE.
- Reset: head=tail=count=0, all busy=0. All registered outputs are 0.
- Issue (issue_flag=1): slot[tail] gets busy=1, ready=0. tail and count advance. The issuer guarantees it does not issue while rob_full=1. Behaviour under such an issue is undefined; the bench must flag it.
- CDB capture: if flag=1 and slot[id-1] is busy, then ready=1 and val is captured. From ex_cdb, jump and target are also captured. Both CDBs may write in the same cycle, always to distinct ids. A CDB with id 0 is ignored.
- Lookup: idN_ready = (idN!=0) & busy & ready. idN_val = val of slot[idN-1], or 0 when not ready.
- Commit: at most one entry per cycle, and only when the head entry is busy and ready and jump_wrong=0. The head entry is retired; head advances and count decrements.
  - REG: flag_ROB=1, rd_ROB=rd, id_ROB=head+1, val_ROB=val.
  - STORE: st_commit_flag=1, st_commit_id=head+1.
  - BRANCH: if jump != pred, then jump_wrong=1 next cycle and correct_pc = jump ? target : pc+4.
  - All commit outputs are single-cycle pulses and are 0 in any cycle with no commit.
- Same-cycle issue and commit: count is unchanged; head and tail both advance.
- Flush: in a cycle where jump_wrong=1, ignore issue, CDB and commit. At that clock edge, set head=tail=count=0, clear all busy bits and drop jump_wrong.
- rst has priority over flush; flush has priority over all other activity.
- Wrap-around: pointers wrap from ROB_SIZE-1 to 0. The id sequence therefore wraps 16 -> 1 and id 0 is never produced.
- Full/empty: with count=0 nothing commits. rob_full asserts at ROB_SIZE-1 to give one cycle of margin for the registered issue path.

Decomposition:
- Shared package (Def.v): ROBBW, REGBW, ROB_SIZE, the type encodings ROB_REG/ROB_STORE/ROB_BR, and the constant NO_ROB=0.
- No sub-module; a single flat module. Slot storage is held as per-field register arrays.

Test Plan:
- Reset, then issue REG rd=5 at pc 0x100 -> alloc_id=1. Send ex_cdb id=1 val=0xAB -> next cycle flag_ROB=1, rd_ROB=5, id_ROB=1, val_ROB=0xAB; id1=1 lookup shows ready=1, val=0xAB before the commit.
- Issue 3 REG entries; complete ids 3 then 2 then 1 out of order -> commits occur in order 1, 2, 3 on consecutive cycles.
- Issue a BRANCH at pc 0x200 with pred=0; ex_cdb jump=1, target=0x300 -> jump_wrong=1 with correct_pc=0x300. Younger completed entries never commit; the next cycle has count=0 and alloc_id=1.
- Issue 15 entries -> rob_full=1 at count 15. Commit one entry and issue one in the same cycle -> count stays 15. Cycle 40 instructions through -> ids wrap 16 -> 1 and no id 0 appears.
- Issue a STORE id=k; ld_cdb id=k -> st_commit_flag=1 with st_commit_id=k, and flag_ROB=0.
- Hold rdy=0 for 5 cycles with the head entry ready -> no commit and state frozen. Assert rst mid-stream -> all outputs 0 and alloc_id=1.
